// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 geometry, scene encoding and colour type.
package vga_pkg;

  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_TOTAL  = 525;
  localparam int VGA_H_VIS_LO = 144;
  localparam int VGA_H_VIS_HI = 783;
  localparam int VGA_V_VIS_LO = 35;
  localparam int VGA_V_VIS_HI = 514;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_V_SYNC   = 2;

  typedef enum logic [1:0] {
    S_TITLE   = 2'd0,
    S_BOARD   = 2'd1,
    S_OVER    = 2'd2,
    S_ILLEGAL = 2'd3
  } scene_e;

  typedef logic [11:0] rgb_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider, H/V raster counters, visible window, raw syncs and frame-boundary strobe.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_TOTAL  = VGA_H_TOTAL,
  parameter int V_TOTAL  = VGA_V_TOTAL,
  parameter int H_VIS_LO = VGA_H_VIS_LO,
  parameter int H_VIS_HI = VGA_H_VIS_HI,
  parameter int V_VIS_LO = VGA_V_VIS_LO,
  parameter int V_VIS_HI = VGA_V_VIS_HI,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int V_SYNC   = VGA_V_SYNC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pix_tick,
  output logic [15:0] h_cnt,
  output logic [15:0] v_cnt,
  output logic        visible,
  output logic        hsync_raw,
  output logic        vsync_raw,
  output logic        boundary
);

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_LO     = 16'(H_VIS_LO);
  localparam logic [15:0] H_HI     = 16'(H_VIS_HI);
  localparam logic [15:0] V_LO     = 16'(V_VIS_LO);
  localparam logic [15:0] V_HI     = 16'(V_VIS_HI);
  localparam logic [15:0] H_SW     = 16'(H_SYNC);
  localparam logic [15:0] V_SW     = 16'(V_SYNC);

  logic [7:0] div_cnt;

  assign pix_tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (pix_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 16'd1;
      end else begin
        h_cnt <= h_cnt + 16'd1;
      end
    end
  end

  assign visible   = (h_cnt >= H_LO) && (h_cnt <= H_HI) && (v_cnt >= V_LO) && (v_cnt <= V_HI);
  assign hsync_raw = (h_cnt >= H_SW);
  assign vsync_raw = (v_cnt >= V_SW);
  assign boundary  = pix_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/vga_scene_sequencer.sv
// VGA timing owner and frame-synchronous scene sequencer selecting one painter per pixel.
//   state     | meaning
//   S_TITLE   | title painter shown; waits for a start after the minimum title time
//   S_BOARD   | battle board painter shown until game_over
//   S_OVER    | game-over painter held for a fixed number of frames
//   S_ILLEGAL | output black; recovers to S_TITLE at the next boundary
module vga_scene_sequencer
  import vga_pkg::*;
#(
  parameter int CLK_DIV          = 4,
  parameter int MIN_TITLE_FRAMES = 60,
  parameter int OVER_FRAMES      = 180,
  parameter int H_TOTAL          = VGA_H_TOTAL,
  parameter int V_TOTAL          = VGA_V_TOTAL,
  parameter int H_VIS_LO         = VGA_H_VIS_LO,
  parameter int H_VIS_HI         = VGA_H_VIS_HI,
  parameter int V_VIS_LO         = VGA_V_VIS_LO,
  parameter int V_VIS_HI         = VGA_V_VIS_HI,
  parameter int H_SYNC           = VGA_H_SYNC,
  parameter int V_SYNC           = VGA_V_SYNC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_req,
  input  logic        game_over,
  input  logic [11:0] title_rgb,
  input  logic [11:0] board_rgb,
  input  logic [11:0] over_rgb,
  output logic [15:0] H_Counter_Value,
  output logic [15:0] V_Counter_Value,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  Red,
  output logic [3:0]  Green,
  output logic [3:0]  Blue,
  output logic [1:0]  scene,
  output logic        frame_start
);

  localparam logic [7:0] TITLE_MIN_CNT = 8'(MIN_TITLE_FRAMES - 1);
  localparam logic [7:0] OVER_END_CNT  = 8'(OVER_FRAMES - 1);

  logic   pix_tick, visible, hsync_raw, vsync_raw, boundary;
  scene_e scene_q, scene_nxt;
  logic   start_pend;
  logic [7:0] frame_cnt;
  rgb_t   pix_src, pix_q;
  logic   hsync_q, vsync_q, frame_start_q;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_VIS_LO(H_VIS_LO),
    .H_VIS_HI(H_VIS_HI),
    .V_VIS_LO(V_VIS_LO),
    .V_VIS_HI(V_VIS_HI),
    .H_SYNC  (H_SYNC),
    .V_SYNC  (V_SYNC)
  ) u_timing (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_tick (pix_tick),
    .h_cnt    (H_Counter_Value),
    .v_cnt    (V_Counter_Value),
    .visible  (visible),
    .hsync_raw(hsync_raw),
    .vsync_raw(vsync_raw),
    .boundary (boundary)
  );

  // A start arriving on the boundary clock itself counts for that boundary.
  always_comb begin
    scene_nxt = S_TITLE;
    case (scene_q)
      S_TITLE: scene_nxt = ((start_pend || start_req) && (frame_cnt >= TITLE_MIN_CNT)) ? S_BOARD : S_TITLE;
      S_BOARD: scene_nxt = game_over ? S_OVER : S_BOARD;
      S_OVER:  scene_nxt = (frame_cnt >= OVER_END_CNT) ? S_TITLE : S_OVER;
      default: scene_nxt = S_TITLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scene_q    <= S_TITLE;
      start_pend <= 1'b0;
      frame_cnt  <= '0;
    end else if (boundary) begin
      scene_q    <= scene_nxt;
      start_pend <= 1'b0;
      if (scene_nxt != scene_q) begin
        frame_cnt <= '0;
      end else if (frame_cnt != 8'hFF) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end else if (start_req) begin
      start_pend <= 1'b1;
    end
  end

  always_comb begin
    pix_src = '0;
    case (scene_q)
      S_TITLE: pix_src = title_rgb;
      S_BOARD: pix_src = board_rgb;
      S_OVER:  pix_src = over_rgb;
      default: pix_src = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (pix_tick) begin
      pix_q   <= visible ? pix_src : '0;
      hsync_q <= hsync_raw;
      vsync_q <= vsync_raw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= boundary;
    end
  end

  assign {Red, Green, Blue} = pix_q;
  assign hsync              = hsync_q;
  assign vsync              = vsync_q;
  assign scene              = scene_q;
  assign frame_start        = frame_start_q;

endmodule

// File: tb/tb_vga_scene_sequencer.sv
// Directed bench for vga_scene_sequencer on a shrunk 20x10 raster so whole frames fit in a short run.
module tb_vga_scene_sequencer;
  import vga_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int FRAME_CLKS = 20 * 10 * CLK_DIV;

  logic        clk, rst_n, start_req, game_over;
  logic [11:0] title_rgb, board_rgb, over_rgb;
  logic [15:0] h_val, v_val;
  logic        hsync, vsync, frame_start;
  logic [3:0]  red, green, blue;
  logic [1:0]  scene;

  int checks = 0;
  int failures = 0;

  vga_scene_sequencer #(
    .CLK_DIV(CLK_DIV), .MIN_TITLE_FRAMES(4), .OVER_FRAMES(5),
    .H_TOTAL(20), .V_TOTAL(10), .H_VIS_LO(4), .H_VIS_HI(15),
    .V_VIS_LO(2), .V_VIS_HI(7), .H_SYNC(3), .V_SYNC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_req(start_req), .game_over(game_over),
    .title_rgb(title_rgb), .board_rgb(board_rgb), .over_rgb(over_rgb),
    .H_Counter_Value(h_val), .V_Counter_Value(v_val),
    .hsync(hsync), .vsync(vsync), .Red(red), .Green(green), .Blue(blue),
    .scene(scene), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    while (n < 2000) begin
      @(posedge clk); #1; n++;
      if (frame_start) return;
    end
    chk("frame_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_hv(input int h, input int v);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (h_val == 16'(h) && v_val == 16'(v)) return;
    end
    chk("hv_timeout", 32'd0, 32'd1);
  endtask

  task automatic measure_low(input bit use_v, output int n);
    int guard;
    n = 0;
    guard = 0;
    while ((use_v ? vsync : hsync) !== 1'b0 && guard < 2000) begin
      @(posedge clk); #1; guard++;
    end
    while ((use_v ? vsync : hsync) === 1'b0 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
  endtask

  function automatic logic [31:0] rgb();
    return 32'({red, green, blue});
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; start_req = 1'b0; game_over = 1'b0;
    title_rgb = 12'h123; board_rgb = 12'h456; over_rgb = 12'h789;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_h", 32'(h_val), 32'd0);
    chk("rst_v", 32'(v_val), 32'd0);
    chk("rst_rgb", rgb(), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_scene", 32'(scene), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_fs(n);
    chk("first_fs_clks", 32'(n), 32'(FRAME_CLKS));
    chk("fs_h0", 32'(h_val), 32'd0);
    chk("fs_v0", 32'(v_val), 32'd0);
    @(posedge clk); #1;
    chk("fs_one_clk", 32'(frame_start), 32'd0);

    // Frame 1: sync width and visible-window edges, RGB lagging H/V by one tick
    measure_low(1'b0, n);
    chk("hsync_low_clks", 32'(n), 32'd12);
    wait_hv(6, 1);  chk("v_above_vis", rgb(), 32'd0);
    wait_hv(0, 2);  chk("vsync_last_low", 32'(vsync), 32'd0);
    wait_hv(1, 2);  chk("vsync_high", 32'(vsync), 32'd1);
    wait_hv(6, 2);  chk("v_first_vis", rgb(), 32'h123);
    wait_hv(4, 3);  chk("h_before_vis", rgb(), 32'd0);
    wait_hv(5, 3);  chk("h_first_vis", rgb(), 32'h123);
    wait_hv(16, 3); chk("h_last_vis", rgb(), 32'h123);
    wait_hv(17, 3); chk("h_after_vis", rgb(), 32'd0);
    wait_hv(5, 7);  chk("v_last_vis", rgb(), 32'h123);
    wait_hv(5, 8);  chk("v_after_vis", rgb(), 32'd0);

    // Frame 2: vsync width, then an early start that must be discarded
    wait_fs(n);
    measure_low(1'b1, n);
    chk("vsync_low_clks", 32'(n), 32'(2 * 20 * CLK_DIV));
    @(posedge clk); #1 start_req = 1'b1;
    @(posedge clk); #1 start_req = 1'b0;
    wait_fs(n);
    chk("early_start_dropped", 32'(scene), 32'd0);
    wait_fs(n);
    chk("pend_cleared", 32'(scene), 32'd0);

    // Start pulse exactly on the boundary clock of an eligible frame
    repeat (FRAME_CLKS - 1) @(posedge clk);
    #1 start_req = 1'b1;
    @(posedge clk); #1;
    start_req = 1'b0;
    chk("boundary_fs", 32'(frame_start), 32'd1);
    chk("boundary_start", 32'(scene), 32'd1);
    wait_hv(5, 2);
    chk("board_first_pix", rgb(), 32'h456);

    game_over = 1'b1;
    wait_fs(n);
    chk("over_enter", 32'(scene), 32'd2);
    game_over = 1'b0;
    wait_hv(5, 2);
    chk("over_pix", rgb(), 32'h789);
    #1 start_req = 1'b1;
    @(posedge clk); #1 start_req = 1'b0;
    wait_fs(n);
    chk("over_ignores_start", 32'(scene), 32'd2);
    repeat (3) wait_fs(n);
    chk("over_hold", 32'(scene), 32'd2);
    wait_fs(n);
    chk("over_exit", 32'(scene), 32'd0);

    // Illegal encoding: black output, recovery to title at the boundary
    wait_hv(5, 3);
    force dut.scene_q = S_ILLEGAL;
    wait_hv(6, 3);
    chk("illegal_black", rgb(), 32'd0);
    chk("illegal_next", 32'(dut.scene_nxt), 32'd0);
    release dut.scene_q;
    wait_fs(n);
    chk("illegal_recover", 32'(scene), 32'd0);

    // Asynchronous reset mid-line
    wait_hv(10, 4);
    chk("pre_reset_pix", rgb(), 32'h123);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_h", 32'(h_val), 32'd0);
    chk("mid_rst_v", 32'(v_val), 32'd0);
    chk("mid_rst_rgb", rgb(), 32'd0);
    chk("mid_rst_hsync", 32'(hsync), 32'd1);
    chk("mid_rst_vsync", 32'(vsync), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs(n);
    chk("restart_fs_clks", 32'(n), 32'(FRAME_CLKS));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scene_sequencer.md
# vga_scene_sequencer

Generates 640x480@60 VGA timing and sequences which full-screen painter drives the monitor: title screen, battle board, game-over screen. Owns the shared `H_Counter_Value`/`V_Counter_Value` bus that all painters decode combinationally. Selects one painter's 12-bit colour per pixel, registers it with sync alignment, and changes scene only on frame boundaries so no frame is torn. Sits between the keyboard/game-logic blocks and the VGA pins.

## Interface

Parameters:
- `CLK_DIV`, 4: system clocks per pixel tick (100 MHz to 25 MHz).
- `MIN_TITLE_FRAMES`, 60: frames the title must be shown before a start is honoured.
- `OVER_FRAMES`, 180: frames the game-over screen is held before returning to title.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_req`  in  1  one-clock pulse from keyboard decoder (Enter pressed).
- `game_over`  in  1  level from game logic; high while a fleet is sunk.
- `title_rgb`  in  12  {R,G,B} from title painter.
- `board_rgb`  in  12  {R,G,B} from board painter.
- `over_rgb`  in  12  {R,G,B} from game-over painter.
- `H_Counter_Value`  out  16  horizontal count, 0..799.
- `V_Counter_Value`  out  16  vertical count, 0..524.
- `hsync`, `vsync`  out  1  active-low syncs, aligned with RGB.
- `Red`, `Green`, `Blue`  out  4 each  registered pixel colour.
- `scene`  out  2  0=TITLE, 1=BOARD, 2=OVER.
- `frame_start`  out  1  one-clock pulse on the tick where counters wrap to (0,0).

## Operation

- Tick divider: `pix_tick` high one clock every `CLK_DIV` clocks; counters, syncs, RGB update only on `pix_tick`.
- H counts 0..799, wraps to 0; V increments on H wrap, 0..524, wraps to 0.
- Visible window: 144 <= H <= 783 and 35 <= V <= 514. Sync: hsync low for H < 96, vsync low for V < 2.
- Pixel stage: on `pix_tick`, RGB <= selected painter colour if (H,V) visible, else 12'h000; hsync/vsync computed from the same (H,V) and registered in the same stage.
- Frame boundary = `pix_tick` with H=799, V=524. Scene register and frame counter update only there.
- `start_pend`: set by `start_req` on any clock, cleared at every frame boundary after evaluation. A pulse on the boundary clock counts for that boundary.
- `frame_cnt`: 8-bit, +1 per boundary, saturates at 255, cleared on every scene change.
- FSM at boundary:
  - TITLE -> BOARD if `start_pend` and frame_cnt >= MIN_TITLE_FRAMES-1; otherwise the pending start is discarded.
  - BOARD -> OVER if `game_over`=1; `start_pend` ignored.
  - OVER -> TITLE when frame_cnt >= OVER_FRAMES-1; starts ignored.
  - Encoding 3 is illegal and goes to TITLE at the next boundary.
- Mux source is `scene`: 0 title, 1 board, 2 over, 3 black.

## Timing

- Reset values: H=V=0, divider=0, scene=TITLE, frame_cnt=0, start_pend=0, RGB=0, hsync=vsync=1, frame_start=0.
- Reset mid-frame: all of the above take effect immediately (async); the first tick after release begins a fresh frame at (0,0).
- Pixel latency: RGB/syncs reflect the counter value from one pixel tick earlier, so H/V out lead RGB by exactly one tick.
- The scene change becomes visible on the first pixel of the new frame (counter (0,0) registered on the following tick).
- `frame_start` is coincident with the clock where H,V become 0,0.

## Structure

- Shared package `vga_pkg`: H/V totals (800/525), visible bounds (144/783, 35/514), sync widths (96/2), scene encoding constants, and the 12-bit colour type.
- One natural sub-module: `vga_timing` (divider, H/V counters, visible flag, raw syncs, boundary strobe). Scene FSM and pixel mux stay in the top level.

## Test plan

- Reset asserted mid-line at H=400: counters read 0, RGB=0, hsync=vsync=1 asynchronously; after release the first `frame_start` occurs at 800*525*4 clocks.
- Free run with CLK_DIV=4: hsync low for exactly 384 clocks per line; vsync low for 2 lines; RGB=0 at H=143 and H=784 with all painters forced to 12'hFFF.
- `start_req` pulse in frame 10 of TITLE is discarded (scene stays 0); pulse in frame 60 gives scene=1 at the next boundary, and the first visible pixel shows `board_rgb`.
- `start_req` on the exact boundary clock in an eligible TITLE frame switches to BOARD at that boundary.
- In BOARD, `game_over` rises mid-frame: scene=2 at the next boundary; after 180 frames scene=0; a `start_req` during OVER has no effect.
- Force scene=3: output is black, and the FSM returns to TITLE at the next boundary.
